// File: rtl/instr_decode_ctrl.sv
// Instruction decode and sequencing controller for the regFileInitializer datapath.
// Optional illegal-instruction trap (sticky flag plus HALT state) enabled by `ILLEGAL_TRAP_EN.
module instr_decode_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [7:0]  opCode,
    output logic [3:0]  a_select,
    output logic [3:0]  b_select,
    output logic [15:0] immediate,
    output logic        use_imm,
    output logic [15:0] regEnable,
    output logic [15:0] retire_count,
    output logic        illegal
);

`ifdef ILLEGAL_TRAP_EN
    typedef enum logic [1:0] {StIdle, StExec, StHalt} state_e;
`else
    typedef enum logic [1:0] {StIdle, StExec} state_e;
`endif

    // Opcodes that never write the destination register.
    localparam logic [7:0] OpNop   = 8'h00;
    localparam logic [7:0] OpCmpu  = 8'h08;
    localparam logic [7:0] OpCmp   = 8'h0B;
    localparam logic [7:0] OpCmpui = 8'h0C;
    localparam logic [7:0] OpCmpi  = 8'hB0;

    state_e      state_q;
    logic [7:0]  opcode_q;
    logic [3:0]  a_sel_q;
    logic [3:0]  b_sel_q;
    logic [15:0] imm_q;
    logic        use_imm_q;
    logic [15:0] reg_en_q;
    logic [15:0] retire_q;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal_q;
    logic        exec_illegal_q;
`endif

    logic [3:0]  f_op;
    logic [3:0]  f_rd;
    logic [3:0]  f_ext;
    logic [3:0]  f_rs;
    logic [7:0]  f_imm8;

    logic [7:0]  dec_opcode;
    logic [3:0]  dec_a_sel;
    logic [3:0]  dec_b_sel;
    logic [15:0] dec_imm;
    logic        dec_use_imm;
    logic [15:0] dec_reg_en;
    logic        dec_illegal;

    assign f_op   = instr[15:12];
    assign f_rd   = instr[11:8];
    assign f_ext  = instr[7:4];
    assign f_rs   = instr[3:0];
    assign f_imm8 = instr[7:0];

    always_comb begin
        dec_opcode  = OpNop;
        dec_a_sel   = 4'h0;
        dec_b_sel   = 4'h0;
        dec_imm     = 16'h0000;
        dec_use_imm = 1'b0;
        dec_illegal = 1'b0;

        case (f_op)
            4'h0: begin
                dec_opcode = {4'h0, f_ext};
                dec_a_sel  = f_rd;
                dec_b_sel  = f_rs;
            end
            4'h8: begin
                case (f_ext)
                    4'h4, 4'h5, 4'h6, 4'h7: begin
                        dec_opcode = {4'h8, f_ext};
                        dec_a_sel  = f_rd;
                        dec_b_sel  = f_rs;
                    end
                    4'h0, 4'h1, 4'h9, 4'hB: begin
                        // Shift-by-immediate: the amount rides in the rs field.
                        dec_opcode  = {4'h8, f_ext};
                        dec_a_sel   = f_rd;
                        dec_imm     = {12'h000, f_rs};
                        dec_use_imm = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            4'h5, 4'h7, 4'h9, 4'hB: begin
                dec_opcode  = {f_op, 4'h0};
                dec_a_sel   = f_rd;
                dec_imm     = {{8{f_imm8[7]}}, f_imm8};
                dec_use_imm = 1'b1;
            end
            4'h1, 4'h2, 4'h3, 4'h4, 4'h6: begin
                dec_opcode  = {f_op, 4'h0};
                dec_a_sel   = f_rd;
                dec_imm     = {8'h00, f_imm8};
                dec_use_imm = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase

        // Illegal instructions run as a bare NOP with every control cleared.
        if (dec_illegal) begin
            dec_opcode  = OpNop;
            dec_a_sel   = 4'h0;
            dec_b_sel   = 4'h0;
            dec_imm     = 16'h0000;
            dec_use_imm = 1'b0;
        end
    end

    always_comb begin
        dec_reg_en = 16'h0001 << dec_a_sel;
        if (dec_opcode == OpNop  || dec_opcode == OpCmpu || dec_opcode == OpCmp ||
            dec_opcode == OpCmpui || dec_opcode == OpCmpi) begin
            dec_reg_en = 16'h0000;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            opcode_q       <= 8'h00;
            a_sel_q        <= 4'h0;
            b_sel_q        <= 4'h0;
            imm_q          <= 16'h0000;
            use_imm_q      <= 1'b0;
            reg_en_q       <= 16'h0000;
            retire_q       <= 16'h0000;
`ifdef ILLEGAL_TRAP_EN
            illegal_q      <= 1'b0;
            exec_illegal_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (instr_valid) begin
                        state_q        <= StExec;
                        opcode_q       <= dec_opcode;
                        a_sel_q        <= dec_a_sel;
                        b_sel_q        <= dec_b_sel;
                        imm_q          <= dec_imm;
                        use_imm_q      <= dec_use_imm;
                        reg_en_q       <= dec_reg_en;
`ifdef ILLEGAL_TRAP_EN
                        exec_illegal_q <= dec_illegal;
`endif
                    end
                end
                StExec: begin
                    // Controls are live for exactly this one cycle.
                    opcode_q  <= 8'h00;
                    a_sel_q   <= 4'h0;
                    b_sel_q   <= 4'h0;
                    imm_q     <= 16'h0000;
                    use_imm_q <= 1'b0;
                    reg_en_q  <= 16'h0000;
                    retire_q  <= retire_q + 16'h0001;
`ifdef ILLEGAL_TRAP_EN
                    if (exec_illegal_q) begin
                        illegal_q <= 1'b1;
                        state_q   <= StHalt;
                    end else begin
                        state_q   <= StIdle;
                    end
`else
                    state_q   <= StIdle;
`endif
                end
`ifdef ILLEGAL_TRAP_EN
                StHalt: begin
                    state_q <= StHalt;
                end
`endif
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign instr_ready  = (state_q == StIdle) & ~reset;
    assign opCode       = opcode_q;
    assign a_select     = a_sel_q;
    assign b_select     = b_sel_q;
    assign immediate    = imm_q;
    assign use_imm      = use_imm_q;
    assign regEnable    = reg_en_q;
    assign retire_count = retire_q;
`ifdef ILLEGAL_TRAP_EN
    assign illegal      = illegal_q;
`else
    assign illegal      = 1'b0;
`endif

endmodule
